// File: rtl/new_usb_ohci_pkg.sv
// -----------------------------------------------------------------------------
// new_usb_ohci_pkg
//
// Purpose : Shared constants and types for the OHCI host-controller frame
//           timing logic. It holds the field widths, the register reset
//           defaults, and the frame-timer state encoding.
//
// Contents:
//   FrWidth / FnWidth / LstWidth  - field widths for FmInterval/FmRemaining/
//                                   PeriodicStart, FmNumber and LSThreshold
//   FmIntervalDefault             - HcFmInterval.FI reset value (12000 bit times - 1)
//   PeriodicStartDefault          - HcPeriodicStart.PS typical value (90 % of a frame)
//   LsThresholdDefault            - HcLSThreshold.LST reset value
//   ft_state_e                    - frame timer run state
// -----------------------------------------------------------------------------
package new_usb_ohci_pkg;

    localparam int FrWidth  = 14;
    localparam int FnWidth  = 16;
    localparam int LstWidth = 12;

    localparam int FmIntervalDefault    = 11999;
    localparam int PeriodicStartDefault = 10800;
    localparam int LsThresholdDefault   = 1576;

    // FT_IDLE means "not started". The first tick after run_i rises reloads
    // the frame counter instead of decrementing it.
    typedef enum logic {
        FT_IDLE = 1'b0,
        FT_RUN  = 1'b1
    } ft_state_e;

endpackage : new_usb_ohci_pkg

// File: rtl/new_usb_frametimer_if.sv
// -----------------------------------------------------------------------------
// new_usb_frametimer_if
//
// Purpose : Groups the frame timer's control, register and event signals.
//           The master side is the HC operational-register block and list
//           service. The slave side is the frame timer.
//
// Signals (directions as seen by the slave / frame timer):
//   run_i            in   HC is in USBOPERATIONAL
//   tick_i           in   one-cycle 12 MHz bit-time strobe
//   fi_i, fit_i      in   HcFmInterval.FI / .FIT
//   ps_i             in   HcPeriodicStart.PS
//   lst_i            in   HcLSThreshold.LST
//   periodic_done_i  in   periodic list exhausted this frame (pulse)
//   fr_o, frt_o      out  HcFmRemaining.FR / .FRT
//   fn_o             out  HcFmNumber.FN
//   frame_periodic_o out  1 = periodic list context
//   sof_o, fno_o     out  SOF and frame-number-overflow pulses
//   below_lst_o      out  remaining time below LS threshold
//   so_o, soc_o      out  schedule-overrun pulse / saturating count
// -----------------------------------------------------------------------------
interface new_usb_frametimer_if #(
    parameter int FrWidth  = new_usb_ohci_pkg::FrWidth,
    parameter int FnWidth  = new_usb_ohci_pkg::FnWidth,
    parameter int LstWidth = new_usb_ohci_pkg::LstWidth
);

    logic                run_i;
    logic                tick_i;
    logic [FrWidth-1:0]  fi_i;
    logic                fit_i;
    logic [FrWidth-1:0]  ps_i;
    logic [LstWidth-1:0] lst_i;
    logic                periodic_done_i;

    logic [FrWidth-1:0]  fr_o;
    logic                frt_o;
    logic [FnWidth-1:0]  fn_o;
    logic                frame_periodic_o;
    logic                sof_o;
    logic                fno_o;
    logic                below_lst_o;
    logic                so_o;
    logic [1:0]          soc_o;

    modport master (
        output run_i, tick_i, fi_i, fit_i, ps_i, lst_i, periodic_done_i,
        input  fr_o, frt_o, fn_o, frame_periodic_o, sof_o, fno_o,
               below_lst_o, so_o, soc_o
    );

    modport slave (
        input  run_i, tick_i, fi_i, fit_i, ps_i, lst_i, periodic_done_i,
        output fr_o, frt_o, fn_o, frame_periodic_o, sof_o, fno_o,
               below_lst_o, so_o, soc_o
    );

endinterface : new_usb_frametimer_if

// File: rtl/new_usb_frametimer.sv
// -----------------------------------------------------------------------------
// new_usb_frametimer
//
// Purpose : OHCI frame timer. It counts full-speed bit times from a
//           synchronised 12 MHz tick and maintains HcFmRemaining and
//           HcFmNumber. It decides when the periodic list context starts
//           (FR at or below HcPeriodicStart) and when it ends (list service
//           reports the periodic list done). It emits SOF and
//           frame-number-overflow pulses, and flags when the remaining frame
//           time is below HcLSThreshold.
//
// Ports   :
//   clk_i  in  SoC clock
//   rst_i  in  synchronous, active-high reset
//   bus    slave modport of new_usb_frametimer_if (see that file)
//
// Build option:
//   NEWUSB_SCHED_OVERRUN_EN - when defined, a frame boundary reached while
//   still in periodic context raises so_o (aligned with sof_o) and bumps the
//   2-bit saturating count soc_o. When undefined, so_o/soc_o are tied to 0.
// -----------------------------------------------------------------------------
module new_usb_frametimer
    import new_usb_ohci_pkg::*;
#(
    parameter int FrWidth  = new_usb_ohci_pkg::FrWidth,
    parameter int FnWidth  = new_usb_ohci_pkg::FnWidth,
    parameter int LstWidth = new_usb_ohci_pkg::LstWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    new_usb_frametimer_if.slave  bus
);

    ft_state_e          state_q, state_d;
    logic [FrWidth-1:0] fr_q, fr_d;
    logic               frt_q, frt_d;
    logic [FnWidth-1:0] fn_q, fn_d;
    logic               entered_q, entered_d;
    logic               periodic_q, periodic_d;
    logic               sof_q, sof_d;
    logic               fno_q, fno_d;
    logic               below_lst_q, below_lst_d;

    logic [FrWidth-1:0] fr_dec;
    logic [FnWidth-1:0] fn_inc;
    logic               done_exit;

`ifdef NEWUSB_SCHED_OVERRUN_EN
    logic               so_q, so_d;
    logic [1:0]         soc_q, soc_d;
`endif

    assign fr_dec = fr_q - FrWidth'(1);
    assign fn_inc = fn_q + FnWidth'(1);

    // Periodic context ends only when the list service reports it empty
    // while we are actually in periodic context. A stray done is ignored.
    assign done_exit = bus.periodic_done_i && periodic_q;

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch. A path that
        // leaves one unassigned would infer a latch.
        state_d    = state_q;
        fr_d       = fr_q;
        frt_d      = frt_q;
        fn_d       = fn_q;
        entered_d  = entered_q;
        periodic_d = periodic_q;
        sof_d      = 1'b0;
        fno_d      = 1'b0;
`ifdef NEWUSB_SCHED_OVERRUN_EN
        so_d       = 1'b0;
        soc_d      = soc_q;
`endif

        // Compare at 32 bits so the widths of FR and LST need not match.
        below_lst_d = (32'(fr_q) < 32'(bus.lst_i));

        if (!bus.run_i) begin
            // Suspended: counters and context freeze. The next run starts a
            // fresh frame from FI.
            state_d = FT_IDLE;
        end else if (bus.tick_i) begin
            if (state_q == FT_IDLE) begin
                // Start of operation: load a full frame and keep FN.
                state_d    = FT_RUN;
                fr_d       = bus.fi_i;
                frt_d      = bus.fit_i;
                entered_d  = 1'b0;
                periodic_d = 1'b0;
                sof_d      = 1'b1;
            end else if (fr_q == '0) begin
                // Frame boundary. The boundary clear wins over a coincident
                // periodic_done_i.
                fr_d       = bus.fi_i;
                frt_d      = bus.fit_i;
                fn_d       = fn_inc;
                entered_d  = 1'b0;
                periodic_d = 1'b0;
                sof_d      = 1'b1;
                fno_d      = fn_inc[FnWidth-1] ^ fn_q[FnWidth-1];
`ifdef NEWUSB_SCHED_OVERRUN_EN
                // The periodic list was still pending when the frame ran out.
                // A done arriving on the boundary cycle counts as finished.
                if (periodic_q && !bus.periodic_done_i) begin
                    so_d = 1'b1;
                    if (soc_q != 2'd3) begin
                        soc_d = soc_q + 2'd1;
                    end
                end
`endif
            end else begin
                fr_d = fr_dec;
                // Test against the post-decrement value so that the context is
                // set in the same cycle FR takes it. Entry beats a coincident
                // done.
                if (!entered_q && (fr_dec <= bus.ps_i)) begin
                    periodic_d = 1'b1;
                    entered_d  = 1'b1;
                end else if (done_exit) begin
                    periodic_d = 1'b0;
                end
            end
        end else if (done_exit) begin
            periodic_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: reset is synchronous. rst_i is only looked at on the clock edge,
    // so it is not in the sensitivity list.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= FT_IDLE;
            fr_q        <= '0;
            frt_q       <= 1'b0;
            fn_q        <= '0;
            entered_q   <= 1'b0;
            periodic_q  <= 1'b0;
            sof_q       <= 1'b0;
            fno_q       <= 1'b0;
            below_lst_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments. Every register samples the
            // pre-edge values, whatever order the statements are in.
            state_q     <= state_d;
            fr_q        <= fr_d;
            frt_q       <= frt_d;
            fn_q        <= fn_d;
            entered_q   <= entered_d;
            periodic_q  <= periodic_d;
            sof_q       <= sof_d;
            fno_q       <= fno_d;
            below_lst_q <= below_lst_d;
        end
    end

`ifdef NEWUSB_SCHED_OVERRUN_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            so_q  <= 1'b0;
            soc_q <= 2'd0;
        end else begin
            so_q  <= so_d;
            soc_q <= soc_d;
        end
    end

    assign bus.so_o  = so_q;
    assign bus.soc_o = soc_q;
`else
    assign bus.so_o  = 1'b0;
    assign bus.soc_o = 2'd0;
`endif

    assign bus.fr_o             = fr_q;
    assign bus.frt_o            = frt_q;
    assign bus.fn_o             = fn_q;
    assign bus.frame_periodic_o = periodic_q;
    assign bus.sof_o            = sof_q;
    assign bus.fno_o            = fno_q;
    assign bus.below_lst_o      = below_lst_q;

endmodule : new_usb_frametimer

// File: tb/tb_new_usb_frametimer.sv
// -----------------------------------------------------------------------------
// tb_new_usb_frametimer
//
// Directed bench for new_usb_frametimer. It uses FI=9, PS=5 and LST=4, and
// sends each tick followed by an idle clock. Expected values come from the
// bench's own frame-number and overrun bookkeeping. The overrun
// expectations follow NEWUSB_SCHED_OVERRUN_EN.
// -----------------------------------------------------------------------------
module tb_new_usb_frametimer;

`ifdef NEWUSB_SCHED_OVERRUN_EN
    localparam bit OvrEn = 1'b1;
`else
    localparam bit OvrEn = 1'b0;
`endif

    localparam int Ps  = 5;
    localparam int Lst = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_pass  = 0;
    int n_total = 0;
    int fn_exp  = 0;
    int soc_exp = 0;
    bit fp_exp  = 1'b0;

    new_usb_frametimer_if bus ();

    new_usb_frametimer dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // One tick cycle. This starts at a negedge and returns at the next one,
    // so the outputs show the result of the tick edge.
    task automatic step();
        bus.tick_i = 1'b1;
        @(negedge clk);
        bus.tick_i = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fr"},  32'(bus.fr_o), 0);
        check({tag, "_frt"}, 32'(bus.frt_o), 0);
        check({tag, "_fn"},  32'(bus.fn_o), 0);
        check({tag, "_fp"},  32'(bus.frame_periodic_o), 0);
        check({tag, "_sof"}, 32'(bus.sof_o), 0);
        check({tag, "_fno"}, 32'(bus.fno_o), 0);
        check({tag, "_blw"}, 32'(bus.below_lst_o), 0);
        check({tag, "_so"},  32'(bus.so_o), 0);
        check({tag, "_soc"}, 32'(bus.soc_o), 0);
    endtask

    // Runs a frame from FR=start_fr down to 0, then the boundary tick.
    // done_at >= 0 pulses periodic_done_i when FR equals that value.
    // done_b drives periodic_done_i on the boundary tick itself.
    task automatic run_frame(input int start_fr, input int done_at,
                             input int reload, input bit done_b);
        bit fp_before;
        bit so_exp;
        int fn_new;
        for (int k = start_fr - 1; k >= 0; k--) begin
            step();
            idle();
            if (k == done_at) begin
                bus.periodic_done_i = 1'b1;
                idle();
                bus.periodic_done_i = 1'b0;
            end
            fp_exp = (k <= Ps) && !(done_at >= 0 && k <= done_at);
            check("fr", 32'(bus.fr_o), k);
            check("fp", 32'(bus.frame_periodic_o), 32'(fp_exp));
            check("below_lst", 32'(bus.below_lst_o), 32'(k < Lst));
        end
        fp_before = fp_exp;
        if (done_b) bus.periodic_done_i = 1'b1;
        step();
        bus.periodic_done_i = 1'b0;
        fn_new = (fn_exp + 1) & 32'hFFFF;
        so_exp = OvrEn && fp_before && !done_b;
        if (so_exp && soc_exp < 3) soc_exp++;
        check("bnd_fr",  32'(bus.fr_o), reload);
        check("bnd_frt", 32'(bus.frt_o), 32'(bus.fit_i));
        check("bnd_fn",  32'(bus.fn_o), fn_new);
        check("bnd_sof", 32'(bus.sof_o), 1);
        check("bnd_fno", 32'(bus.fno_o), 32'(((fn_new >> 15) & 1) != ((fn_exp >> 15) & 1)));
        check("bnd_fp",  32'(bus.frame_periodic_o), 0);
        check("bnd_so",  32'(bus.so_o), 32'(so_exp));
        check("bnd_soc", 32'(bus.soc_o), soc_exp);
        fn_exp = fn_new;
        fp_exp = 1'b0;
        idle();
        check("post_sof", 32'(bus.sof_o), 0);
        check("post_fno", 32'(bus.fno_o), 0);
        check("post_so",  32'(bus.so_o), 0);
    endtask

    initial begin
        bus.run_i           = 1'b0;
        bus.tick_i          = 1'b0;
        bus.fi_i            = 14'd9;
        bus.fit_i           = 1'b1;
        bus.ps_i            = 14'(Ps);
        bus.lst_i           = 12'(Lst);
        bus.periodic_done_i = 1'b0;

        // Reset state
        repeat (3) idle();
        check_all_zero("rst");
        rst = 1'b0;
        idle();

        // Start: the first tick loads FI and SOF pulses once
        bus.run_i = 1'b1;
        step();
        check("start_fr",  32'(bus.fr_o), 9);
        check("start_frt", 32'(bus.frt_o), 1);
        check("start_sof", 32'(bus.sof_o), 1);
        check("start_fn",  32'(bus.fn_o), 0);
        idle();
        check("start_sof_end", 32'(bus.sof_o), 0);
        check("start_below",   32'(bus.below_lst_o), 0);

        // Overrun sequence: soc counts 1, -, 2, 3, -(done on boundary), 3
        run_frame(9, -1, 9, 1'b0);
        run_frame(9,  3, 9, 1'b0);
        run_frame(9, -1, 9, 1'b0);
        run_frame(9, -1, 9, 1'b0);
        run_frame(9, -1, 9, 1'b1);
        run_frame(9, -1, 9, 1'b0);

        // Frame-number overflow at 0x7FFF->0x8000 and 0xFFFF->0x0000
        force dut.fn_q = 16'h7FFF;
        @(posedge clk);
        @(negedge clk);
        release dut.fn_q;
        fn_exp = 32'h7FFF;
        run_frame(9, -1, 9, 1'b0);
        force dut.fn_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.fn_q;
        fn_exp = 32'hFFFF;
        run_frame(9, -1, 9, 1'b0);
        run_frame(9, -1, 9, 1'b0);

        // A mid-frame FI/FIT change applies only at the next reload
        bus.fi_i  = 14'd6;
        bus.fit_i = 1'b0;
        run_frame(9, -1, 6, 1'b0);

        // run_i low: everything holds and there is no SOF. Rerun restarts
        // from FI.
        bus.run_i = 1'b0;
        step();
        check("stop_fr",  32'(bus.fr_o), 6);
        check("stop_sof", 32'(bus.sof_o), 0);
        check("stop_fn",  32'(bus.fn_o), fn_exp);
        bus.run_i = 1'b1;
        step();
        check("restart_fr",  32'(bus.fr_o), 6);
        check("restart_sof", 32'(bus.sof_o), 1);
        check("restart_fn",  32'(bus.fn_o), fn_exp);

        // Reset asserted at FR=4 while in periodic context
        step();
        step();
        check("pre_rst_fr", 32'(bus.fr_o), 4);
        check("pre_rst_fp", 32'(bus.frame_periodic_o), 1);
        rst = 1'b1;
        idle();
        check_all_zero("mid_rst");
        rst = 1'b0;
        fn_exp  = 0;
        soc_exp = 0;
        step();
        check("rst_reload_fr",  32'(bus.fr_o), 6);
        check("rst_reload_sof", 32'(bus.sof_o), 1);
        check("rst_reload_fn",  32'(bus.fn_o), 0);
        check("rst_reload_fp",  32'(bus.frame_periodic_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_new_usb_frametimer
